// File: rtl/reg_file_ab_if.sv
// Operand-side bus of the register file: two read ports, one write-back port,
// clear request and status.
interface reg_file_ab_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 7
);
  logic [ADDR_W-1:0] Addr_A;
  logic [ADDR_W-1:0] Addr_B;
  logic [ADDR_W-1:0] Addr_C;
  logic [DATA_W-1:0] RegPort_C;
  logic              Write_RegC;
  logic              Clr_Regs;
  logic [DATA_W-1:0] RegPort_A;
  logic [DATA_W-1:0] RegPort_B;
  logic              Reg_Busy;
  logic              Wr_Drop;

  modport master (
    output Addr_A, Addr_B, Addr_C, RegPort_C, Write_RegC, Clr_Regs,
    input  RegPort_A, RegPort_B, Reg_Busy, Wr_Drop
  );

  modport slave (
    input  Addr_A, Addr_B, Addr_C, RegPort_C, Write_RegC, Clr_Regs,
    output RegPort_A, RegPort_B, Reg_Busy, Wr_Drop
  );
endinterface

// File: rtl/reg_file_ab.sv
// Two-read / one-write register file with a one-entry write-back stage, read
// forwarding and a sequential clear engine run after reset and on request.
module reg_file_ab #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DEPTH   = 128,
  parameter bit          ZERO_R0 = 1'b1
) (
  input logic          clk,
  input logic          reset_n,
  reg_file_ab_if.slave rf
);

  typedef enum logic [1:0] {StInit, StReady, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              busy_q, busy_d;
  logic              wr_drop_q, wr_drop_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              wr_r0;
  logic [DATA_W-1:0] rd_a, rd_b;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wr_drop_d  = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = clr_cnt_q;
    mem_wdata  = '0;
    wr_r0      = ZERO_R0 && (rf.Addr_C == '0);

    unique case (state_q)
      StInit, StClear: begin
        mem_we    = 1'b1;
        wr_drop_d = rf.Write_RegC;
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d   = StReady;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StReady: begin
        // Pending write-back commits even on the clear edge; the clear overwrites it later.
        mem_we    = wb_valid_q;
        mem_waddr = wb_addr_q;
        mem_wdata = wb_data_q;
        if (rf.Clr_Regs) begin
          state_d   = StClear;
          clr_cnt_d = '0;
          wr_drop_d = rf.Write_RegC;
        end else if (rf.Write_RegC && !wr_r0) begin
          wb_valid_d = 1'b1;
          wb_addr_d  = rf.Addr_C;
          wb_data_d  = rf.RegPort_C;
        end
      end
      default: state_d = StInit;
    endcase

    busy_d = (state_d != StReady);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StInit;
      clr_cnt_q  <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      busy_q     <= 1'b1;
      wr_drop_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      busy_q     <= busy_d;
      wr_drop_q  <= wr_drop_d;
    end
  end

  // Array contents are not reset; the clear engine zeroes them.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    rd_a = mem_q[rf.Addr_A];
    if (busy_q || (ZERO_R0 && (rf.Addr_A == '0))) begin
      rd_a = '0;
    end else if (wb_valid_q && (wb_addr_q == rf.Addr_A)) begin
      rd_a = wb_data_q;
    end
  end

  always_comb begin
    rd_b = mem_q[rf.Addr_B];
    if (busy_q || (ZERO_R0 && (rf.Addr_B == '0))) begin
      rd_b = '0;
    end else if (wb_valid_q && (wb_addr_q == rf.Addr_B)) begin
      rd_b = wb_data_q;
    end
  end

  assign rf.RegPort_A = rd_a;
  assign rf.RegPort_B = rd_b;
  assign rf.Reg_Busy  = busy_q;
  assign rf.Wr_Drop   = wr_drop_q;

endmodule

// File: tb/tb_reg_file_ab.sv
// Directed vector bench for reg_file_ab: init window, forwarding, streaming
// writes, register 0, clear-with-write and reset during clear.
module tb_reg_file_ab;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  reg_file_ab_if #(.DATA_W(16), .ADDR_W(7)) rf ();

  reg_file_ab #(
    .DATA_W (16),
    .ADDR_W (7),
    .DEPTH  (128),
    .ZERO_R0(1'b1)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .rf     (rf)
  );

  typedef struct {
    logic        we;
    logic [6:0]  ac;
    logic [15:0] wd;
    logic [6:0]  aa;
    logic [6:0]  ab;
    logic [15:0] ea;
    logic [15:0] eb;
    logic        ed;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with Reg_Busy high (bounded) and Wr_Drop pulses seen in that window.
  task automatic count_busy(output int cycles, output int drops);
    cycles = 0;
    drops  = 0;
    while (rf.Reg_Busy === 1'b1 && cycles < 300) begin
      if (rf.Wr_Drop === 1'b1) drops++;
      if (rf.RegPort_A !== 16'h0) drops += 1000;
      cycles++;
      tick();
    end
  endtask

  initial begin
    int bad;
    int cyc;
    int drp;

    vecs[0]  = '{1'b1, 7'd7, 16'hBEEF, 7'd7, 7'd7, 16'h0000, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 7'd0, 16'h0000, 7'd7, 7'd7, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[2]  = '{1'b0, 7'd0, 16'h0000, 7'd7, 7'd7, 16'hBEEF, 16'hBEEF, 1'b0};
    vecs[3]  = '{1'b1, 7'd3, 16'h0001, 7'd3, 7'd7, 16'h0000, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b1, 7'd3, 16'h0002, 7'd3, 7'd3, 16'h0001, 16'h0001, 1'b0};
    vecs[5]  = '{1'b0, 7'd0, 16'h0000, 7'd3, 7'd7, 16'h0002, 16'hBEEF, 1'b0};
    vecs[6]  = '{1'b0, 7'd0, 16'h0000, 7'd3, 7'd0, 16'h0002, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 7'd0, 16'hFFFF, 7'd0, 7'd3, 16'h0000, 16'h0002, 1'b0};
    vecs[8]  = '{1'b0, 7'd0, 16'h0000, 7'd0, 7'd0, 16'h0000, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 7'd1, 16'hA5A5, 7'd1, 7'd2, 16'h0000, 16'h0000, 1'b0};
    vecs[10] = '{1'b1, 7'd2, 16'hA5A5, 7'd1, 7'd2, 16'hA5A5, 16'h0000, 1'b0};
    vecs[11] = '{1'b1, 7'd3, 16'hA5A5, 7'd1, 7'd2, 16'hA5A5, 16'hA5A5, 1'b0};

    rf.Addr_A     = 7'd5;
    rf.Addr_B     = 7'd0;
    rf.Addr_C     = 7'd5;
    rf.RegPort_C  = 16'h1234;
    rf.Write_RegC = 1'b1;
    rf.Clr_Regs   = 1'b0;

    repeat (3) tick();
    check("reset_busy", 32'(rf.Reg_Busy), 32'd1);
    check("reset_drop", 32'(rf.Wr_Drop), 32'd0);
    check("reset_port_a", 32'(rf.RegPort_A), 32'h0);

    // Writes held through the whole init window are all dropped.
    reset_n = 1'b1;
    bad = 0;
    for (int k = 1; k <= 128; k++) begin
      tick();
      if (rf.Wr_Drop !== 1'b1) bad++;
      if (rf.RegPort_A !== 16'h0) bad++;
      if (k < 128 && rf.Reg_Busy !== 1'b1) bad++;
    end
    check("init_window_errors", 32'(bad), 32'd0);
    check("init_busy_done", 32'(rf.Reg_Busy), 32'd0);
    rf.Write_RegC = 1'b0;
    #1;
    check("init_reg5_zero", 32'(rf.RegPort_A), 32'h0);
    tick();

    for (int i = 0; i < 12; i++) begin
      rf.Write_RegC = vecs[i].we;
      rf.Addr_C     = vecs[i].ac;
      rf.RegPort_C  = vecs[i].wd;
      rf.Addr_A     = vecs[i].aa;
      rf.Addr_B     = vecs[i].ab;
      #1;
      check($sformatf("vec%0d_a", i), 32'(rf.RegPort_A), 32'(vecs[i].ea));
      check($sformatf("vec%0d_b", i), 32'(rf.RegPort_B), 32'(vecs[i].eb));
      check($sformatf("vec%0d_drop", i), 32'(rf.Wr_Drop), 32'(vecs[i].ed));
      tick();
    end

    // Clear request with a simultaneous write while reg 3 is still in write-back.
    rf.Clr_Regs   = 1'b1;
    rf.Write_RegC = 1'b1;
    rf.Addr_C     = 7'd9;
    rf.RegPort_C  = 16'h1111;
    rf.Addr_A     = 7'd3;
    #1;
    check("clr_pre_fwd", 32'(rf.RegPort_A), 32'hA5A5);
    check("clr_pre_busy", 32'(rf.Reg_Busy), 32'd0);
    tick();
    rf.Clr_Regs   = 1'b0;
    rf.Write_RegC = 1'b0;
    count_busy(cyc, drp);
    check("clr_busy_cycles", 32'(cyc), 32'd128);
    check("clr_drop_pulses", 32'(drp), 32'd1);
    rf.Addr_A = 7'd1;
    rf.Addr_B = 7'd3;
    #1;
    check("clr_reg1", 32'(rf.RegPort_A), 32'h0);
    check("clr_reg3", 32'(rf.RegPort_B), 32'h0);
    rf.Addr_A = 7'd9;
    rf.Addr_B = 7'd7;
    #1;
    check("clr_reg9", 32'(rf.RegPort_A), 32'h0);
    check("clr_reg7", 32'(rf.RegPort_B), 32'h0);
    tick();

    // Reset in the middle of a clear restarts the full init sequence.
    rf.Write_RegC = 1'b1;
    rf.Addr_C     = 7'd10;
    rf.RegPort_C  = 16'h5555;
    tick();
    rf.Write_RegC = 1'b0;
    tick();
    rf.Addr_A = 7'd10;
    #1;
    check("pre_reset_reg10", 32'(rf.RegPort_A), 32'h5555);
    rf.Clr_Regs = 1'b1;
    tick();
    rf.Clr_Regs = 1'b0;
    repeat (60) tick();
    check("midclr_busy", 32'(rf.Reg_Busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midclr_rst_busy", 32'(rf.Reg_Busy), 32'd1);
    check("midclr_rst_drop", 32'(rf.Wr_Drop), 32'd0);
    #1;
    reset_n = 1'b1;
    count_busy(cyc, drp);
    check("rst_busy_cycles", 32'(cyc), 32'd128);
    check("rst_drop_pulses", 32'(drp), 32'd0);
    rf.Addr_A = 7'd10;
    rf.Addr_B = 7'd7;
    #1;
    check("rst_reg10", 32'(rf.RegPort_A), 32'h0);
    check("rst_reg7", 32'(rf.RegPort_B), 32'h0);

    rf.Write_RegC = 1'b1;
    rf.Addr_C     = 7'd20;
    rf.RegPort_C  = 16'h1357;
    rf.Addr_A     = 7'd20;
    tick();
    rf.Write_RegC = 1'b0;
    #1;
    check("post_rst_fwd", 32'(rf.RegPort_A), 32'h1357);
    tick();
    check("post_rst_array", 32'(rf.RegPort_A), 32'h1357);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
